// File: rtl/seq_ctrl_pkg.sv
// Shared types and default sizing for the step-button sequence controller.
// The state enum lives here so the controller and any future debug tap agree on encoding.
package seq_ctrl_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_CNT_W           = 8;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        STEP,
        RELEASE_WAIT
    } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level into the local clock domain.
// Both flops clear on reset so a held input is re-sampled from scratch afterwards.
module sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/seq_step_controller.sv
// Debounced single-step controller driving a pair of Moore/Mealy detector FSMs,
// counting their detections and flagging any disagreement between them.
module seq_step_controller
    import seq_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic             Clock50M,
    input  logic             Reset_n,
    input  logic             rawclock,
    input  logic             A,
    input  logic             Z_moore,
    input  logic             Z_mealy,
    output logic             step,
    output logic             A_held,
    output logic [CNT_W-1:0] moore_count,
    output logic [CNT_W-1:0] mealy_count,
    output logic             mismatch,
    output logic             busy
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE  = DB_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic w_rc_s;
    logic w_a_s;

    state_t           r_state;
    logic [DB_W-1:0]  r_db_cnt;
    logic             r_step;
    logic             r_a_held;
    logic             r_busy;
    logic [CNT_W-1:0] r_moore_count;
    logic [CNT_W-1:0] r_mealy_count;
    logic             r_mismatch;
    logic             r_mealy_prev;
    logic             r_first_done;

    sync2 u_sync_rc (
        .i_clk   (Clock50M),
        .i_rst_n (Reset_n),
        .i_d     (rawclock),
        .o_q     (w_rc_s)
    );

    sync2 u_sync_a (
        .i_clk   (Clock50M),
        .i_rst_n (Reset_n),
        .i_d     (A),
        .o_q     (w_a_s)
    );

    // Press must stay high a full window to fire; release must stay low a full window to re-arm.
    always_ff @(posedge Clock50M or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= IDLE;
            r_db_cnt <= '0;
            r_step   <= 1'b0;
            r_a_held <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_step <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rc_s) begin
                        r_state  <= PRESS_WAIT;
                        r_db_cnt <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_rc_s) begin
                        r_state  <= IDLE;
                        r_db_cnt <= '0;
                        r_busy   <= 1'b0;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state  <= STEP;
                        r_db_cnt <= '0;
                        r_step   <= 1'b1;
                        r_a_held <= w_a_s;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_ONE;
                    end
                end
                STEP: begin
                    r_state  <= RELEASE_WAIT;
                    r_db_cnt <= '0;
                end
                RELEASE_WAIT: begin
                    if (w_rc_s) begin
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state  <= IDLE;
                        r_db_cnt <= '0;
                        r_busy   <= 1'b0;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_ONE;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_db_cnt <= '0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    // Z_mealy reflects this step's result, Z_moore the previous step's, so Moore is checked against the stored Mealy bit.
    always_ff @(posedge Clock50M or negedge Reset_n) begin
        if (!Reset_n) begin
            r_moore_count <= '0;
            r_mealy_count <= '0;
            r_mismatch    <= 1'b0;
            r_mealy_prev  <= 1'b0;
            r_first_done  <= 1'b0;
        end else if (r_state == STEP) begin
            if (Z_moore && (r_moore_count != CNT_SAT)) begin
                r_moore_count <= r_moore_count + CNT_ONE;
            end
            if (Z_mealy && (r_mealy_count != CNT_SAT)) begin
                r_mealy_count <= r_mealy_count + CNT_ONE;
            end
            if (r_first_done && (Z_moore != r_mealy_prev)) begin
                r_mismatch <= 1'b1;
            end
            r_mealy_prev <= Z_mealy;
            r_first_done <= 1'b1;
        end
    end

    assign step        = r_step;
    assign A_held      = r_a_held;
    assign busy        = r_busy;
    assign moore_count = r_moore_count;
    assign mealy_count = r_mealy_count;
    assign mismatch    = r_mismatch;

endmodule
